// File: rtl/i2c_slave_read_port.sv
`default_nettype none
// ============================================================================
// Module : i2c_slave_read_port
// Desc   : I2C slave that takes a 1-byte buffer pointer on writes and streams
//          buffer bytes on reads. I2C_SLV_TIMEOUT_EN adds an SCL-low abort.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_slave_read_port #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
    parameter int          ADDR_W      = 5,
    parameter logic [19:0] TIMEOUT_CYC = 20'd500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] RADD,
    input  logic [7:0]        DOUT,
    output logic              busy,
    output logic              rd_strb
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_RD_LOAD, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              ptr_done_q, ptr_done_d;
    logic [ADDR_W-1:0] radd_q, radd_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              rd_strb_q, rd_strb_d;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_timeout;
    logic [7:0] w_byte;

    assign w_scl_rise = scl_sync_q & ~scl_prev_q;
    assign w_scl_fall = ~scl_sync_q & scl_prev_q;
    assign w_start    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign w_stop     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    assign w_byte     = {shift_q[6:0], sda_sync_q};

`ifdef I2C_SLV_TIMEOUT_EN
    logic [19:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = 20'd0;
        if (busy_q && !scl_sync_q)
            to_cnt_d = to_cnt_q + 20'd1;
    end

    assign w_timeout = busy_q && !scl_sync_q && (to_cnt_q == TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (reset) to_cnt_q <= 20'd0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ptr_done_d = ptr_done_q;
        radd_d     = radd_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rd_strb_d  = 1'b0;
        if (w_start) begin
            state_d    = S_ADDR;
            bitcnt_d   = 4'd0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            ptr_done_d = 1'b0;
        end else if (w_stop || w_timeout) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ADDR: if (w_scl_rise) begin
                    shift_d  = w_byte;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d = 4'd0;
                        rw_d     = sda_sync_q;
                        if (shift_q[6:0] == SLAVE_ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                // Reads hand over to RD_LOAD while ACK is still held; the next
                // fall both ends the ACK and presents the first data bit.
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                        if (rw_q) state_d = S_RD_LOAD;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_PTR;
                    end
                end
                S_PTR: if (w_scl_rise) begin
                    shift_d  = w_byte;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        bitcnt_d = 4'd0;
                        state_d  = S_PTR_ACK;
                        if (!ptr_done_q) begin
                            radd_d     = w_byte[ADDR_W-1:0];
                            ptr_done_d = 1'b1;
                        end
                    end
                end
                S_PTR_ACK: if (w_scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_PTR;
                    end
                end
                S_RD_LOAD: if (w_scl_fall) begin
                    shift_d   = DOUT;
                    rd_strb_d = 1'b1;
                    sda_oe_d  = ~DOUT[7];
                    bitcnt_d  = 4'd1;
                    state_d   = S_RD_BYTE;
                end
                S_RD_BYTE: if (w_scl_fall) begin
                    if (bitcnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RD_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                S_RD_ACK: if (w_scl_rise) begin
                    if (!sda_sync_q) begin
                        radd_d  = radd_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = S_RD_LOAD;
                    end else begin
                        state_d = S_WAIT_STOP;
                    end
                end
                S_WAIT_STOP: sda_oe_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'd0;
            rw_q       <= 1'b0;
            ptr_done_q <= 1'b0;
            radd_q     <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_strb_q  <= 1'b0;
        end else begin
            scl_meta_q <= scl_in;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ptr_done_q <= ptr_done_d;
            radd_q     <= radd_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rd_strb_q  <= rd_strb_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign RADD    = radd_q;
    assign busy    = busy_q;
    assign rd_strb = rd_strb_q;

endmodule
`default_nettype wire
